uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmit path (TX FIFO write port) between NUM_REQ byte-stream requesters, for example a CPU register port, a debug logger and a DMA engine. Each requester sends packets as valid/ready byte streams with a last flag. Grants are round-robin and packet-locked, so bytes from different requesters never interleave on the wire. The block sits between the requesters and the TX FIFO write side of the UART top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of the grant index (derived, not overridden)
TIMEOUT_W, 16, width of the stall-timeout counter (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
req_data  in  NUM_REQ*8  byte per requester; requester i occupies [8*i+7:8*i]
req_last  in  NUM_REQ  last byte of packet, per requester
req_valid  in  NUM_REQ  byte valid, per requester
req_ready  out  NUM_REQ  byte accepted, per requester
req_mask  in  NUM_REQ  requester enable; 0 excludes the requester from new grants
m_data  out  8  byte to TX FIFO
m_valid  out  1  byte valid to TX FIFO
m_ready  in  1  TX FIFO can accept (~fifo_tx_full)
grant_id  out  ID_W  currently or last granted requester
busy  out  1  1 while a packet lock is held
timeout_cycles  in  TIMEOUT_W  stall limit; present only with UART_ARB_TIMEOUT_EN
timeout_pulse  out  1  one-cycle lock-abort strobe; present only with UART_ARB_TIMEOUT_EN

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk.
- Reset values:
  - m_valid=0, m_data=0, req_ready=0, grant_id=0, busy=0, timeout_pulse=0.
  - Internal last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, LOCK.
- IDLE:
  - An eligible requester has req_valid[i]&req_mask[i].
  - Pick the first eligible index searching upward from pointer+1, with modulo NUM_REQ wrap.
  - On the next clock: register grant_id, set busy=1, go to LOCK.
  - With no eligible requester, stay in IDLE.
  - req_ready is all-zero in IDLE; grant latency is 1 cycle.
- LOCK:
  - req_ready[grant_id] = (!m_valid | m_ready); all other req_ready bits are 0.
  - A transfer happens when req_valid[g] & req_ready[g]. On a transfer: m_data <= req_data[g], m_valid <= 1.
  - If m_valid & m_ready and there is no new transfer, m_valid <= 0.
  - This output register gives full throughput: 1 byte per cycle while m_ready stays 1.
  - A transfer with req_last[g]=1 moves the FSM to IDLE on the next clock: pointer <= g, busy <= 0.
  - There is one idle arbitration cycle between packets.
- Output: m_data is held stable while m_valid & !m_ready (AXI-Stream style).
- Boundary conditions:
  - Clearing req_mask[g] mid-packet does not break the lock. The packet completes, and the mask applies to later grants only.
  - If only one requester is eligible, it is re-granted after the one idle cycle.
  - If m_ready is low for a long time, req_ready stays 0 and there is no data loss.
  - Asserting reset mid-packet drops the lock and the held byte immediately. Priority restarts from requester 0.
  - req_last on a single-byte packet is legal: LOCK lasts exactly one transfer.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W counter clears on entry to LOCK and on every transfer.
  - It increments each LOCK cycle in which req_valid[g]=0.
  - When the counter reaches timeout_cycles (value != 0), the FSM goes to IDLE with pointer <= g, busy <= 0, and timeout_pulse=1 for one cycle.
  - A byte already in m_data is still delivered.
  - timeout_cycles=0 disables the timeout.
- Undefined:
  - The timeout_cycles and timeout_pulse ports are absent.
  - The lock is held until req_last, with no limit.

Decomposition:
- Package uart_arb_pkg: state enum {IDLE, LOCK}, the byte-width constant BYTE_W=8, and the default NUM_REQ.
- Sub-module uart_rr_picker: a combinational round-robin picker.
  - Inputs: eligible vector, pointer.
  - Outputs: found, index.
  - It is reusable for the RX-side demux later.

Test Plan:
1. Req0 sends a 3-byte packet (0x11,0x22,0x33 last) with m_ready=1. Required: grant_id=0 one cycle after valid; m_valid for 3 consecutive cycles with bytes in order; busy drops after the last byte.
2. Req1 and req2 both hold 2-byte packets from reset. Required: req1 is served fully, then req2. The wire order is 1a,1b,2a,2b with no interleaving. The pointer ends at 2.
3. All 4 requesters are continuously valid with 1-byte packets. Required: grant order 0,1,2,3,0,1 (fairness wrap-around).
4. m_ready is toggled 1,0,0,1 mid-packet. Required: m_data holds while m_ready=0, req_ready[g]=0 during the stall, and no byte is lost or duplicated.
5. req_mask[1] is cleared in the middle of req1's 4-byte packet, while req3 is pending. Required: req1 completes all 4 bytes; req3 is granted next; req1 is not re-granted while masked.
6. (UART_ARB_TIMEOUT_EN) timeout_cycles=5; req0 sends 1 byte without last, then drops valid. Required: timeout_pulse fires on the 5th stalled cycle, busy=0, and req2 (pending) is granted on the following cycle.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of i_eligible
// found by searching upward from i_ptr+1 with wrap-around. Generic so the
// receive-side demux can reuse it.
module uart_rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_eligible,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_found,
    output logic [ID_W-1:0] o_index
);

    // w_cand[k] is the requester index at search offset k+1 from the pointer.
    logic [ID_W-1:0] w_cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign w_cand[gi] = ID_W'((int'(i_ptr) + gi + 1) % N);
        end
    endgenerate

    // Scan from the farthest offset to the nearest so the nearest eligible one wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_eligible[w_cand[k]]) begin
                o_found = 1'b1;
                o_index = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the UART TX FIFO write port
// between NUM_REQ byte-stream requesters. A registered output stage gives one
// byte per cycle while m_ready stays high and holds m_data during stalls.
// Optional stall timeout: define UART_ARB_TIMEOUT_EN to add timeout_cycles /
// timeout_pulse and abort a lock whose owner stops presenting data.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEFAULT_NUM_REQ,
`ifdef UART_ARB_TIMEOUT_EN
    parameter int TIMEOUT_W = 16,
`endif
    // Derived from NUM_REQ; not meant to be overridden.
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_mask,
    output logic [BYTE_W-1:0]         m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    input  logic [TIMEOUT_W-1:0]      timeout_cycles,
    output logic                      timeout_pulse
`endif
);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     w_pick;
    logic                w_found;
    logic [NUM_REQ-1:0]  w_eligible;
    logic [BYTE_W-1:0]   w_bytes [NUM_REQ];
    logic [BYTE_W-1:0]   w_sel_data;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic                w_can_accept;
    logic                w_xfer;
    logic                w_timeout_hit;
    logic [BYTE_W-1:0]   r_m_data;
    logic                r_m_valid;

    assign w_eligible = req_valid & req_mask;

    uart_rr_picker #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_found    (w_found),
        .o_index    (w_pick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign w_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    assign w_sel_data  = w_bytes[r_grant];
    assign w_sel_valid = req_valid[r_grant];
    assign w_sel_last  = req_last[r_grant];
    // The output register can take a new byte when empty or draining this cycle.
    assign w_can_accept = !r_m_valid || m_ready;
    assign w_xfer       = (r_state == LOCK) && w_sel_valid && w_can_accept;

`ifdef UART_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_stall_cnt;
    logic [TIMEOUT_W-1:0] w_stall_inc;
    logic                 r_timeout_pulse;

    assign w_stall_inc   = r_stall_cnt + TIMEOUT_W'(1);
    // Fires on the stalled cycle that brings the count up to the limit.
    assign w_timeout_hit = (r_state == LOCK) && !w_sel_valid
                        && (timeout_cycles != '0) && (w_stall_inc == timeout_cycles);

    // Stall counter restarts on every new lock and every accepted byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt     <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_timeout_hit;
            if ((r_state == IDLE) || w_xfer) begin
                r_stall_cnt <= '0;
            end else if (!w_sel_valid) begin
                r_stall_cnt <= w_stall_inc;
            end
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    assign w_timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: grant on any eligible requester, release on last byte or timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_next = LOCK;
            LOCK:    if ((w_xfer && w_sel_last) || w_timeout_hit) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Only the lock owner sees ready, and only when the output stage has room.
    always_comb begin
        req_ready = '0;
        if (r_state == LOCK) begin
            req_ready[r_grant] = w_can_accept;
        end
    end

    // Grant/pointer bookkeeping and the output holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant   <= '0;
            r_ptr     <= ID_W'(NUM_REQ - 1);
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_found) begin
                r_grant <= w_pick;
            end
            if ((r_state == LOCK) && (w_state_next == IDLE)) begin
                r_ptr <= r_grant;
            end
            if (w_xfer) begin
                r_m_data  <= w_sel_data;
                r_m_valid <= 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_data   = r_m_data;
    assign m_valid  = r_m_valid;
    assign grant_id = r_grant;
    assign busy     = (r_state == LOCK);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. Directed packets are queued per
// requester; the expected wire bytes and grant order are pushed by hand and
// popped by an independent monitor. Define UART_ARB_TIMEOUT_EN to add the
// stall-timeout scenario.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     req_mask;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic [IDW-1:0]   grant_id;
    logic             busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]      timeout_cycles;
    logic             timeout_pulse;
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_mask       (req_mask),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .grant_id       (grant_id),
        .busy           (busy)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_cycles (timeout_cycles),
        .timeout_pulse  (timeout_pulse)
`endif
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         stall_cycles = 0;
    logic [8:0] src_q [N][$];   // {last, data} per requester
    logic [7:0] exp_q [$];      // expected wire bytes, in order
    int         exp_grant_q [$];
    bit         rdy_q [$];      // m_ready pattern, one entry per cycle

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input string what);
        n_vec++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic src(input int r, input logic [7:0] d, input bit last);
        src_q[r].push_back({last, d});
    endtask

    task automatic flush_all();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        exp_grant_q.delete();
        rdy_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        flush_all();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() > 0 || exp_grant_q.size() > 0 || busy || m_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_drain"}, 32'(t < 300), 1);
        @(negedge clk);
    endtask

    // Requester model: consume on the handshake seen mid-cycle, present the next byte after the edge.
    initial begin : driver
        bit         hs [N];
        logic [8:0] head;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) hs[i] = req_valid[i] && req_ready[i] && reset_n;
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    head = src_q[i][0];
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = head[7:0];
                    req_last[i]         = head[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // TX FIFO model: m_ready follows the queued pattern, otherwise stays high.
    initial begin : sink
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        end
    end

    // Monitor: grants, accepted bytes, and stall behaviour.
    initial begin : monitor
        logic       prev_busy;
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_busy  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_busy  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    if (exp_grant_q.size() == 0)
                        fail_msg("grant", $sformatf("unexpected grant to %0d", grant_id));
                    else
                        chk("grant", 32'(grant_id), exp_grant_q.pop_front());
                end
                if (prev_stall) begin
                    chk("hold_valid", 32'(m_valid), 1);
                    chk("hold_data", 32'(m_data), 32'(prev_data));
                end
                if (m_valid && !m_ready) begin
                    stall_cycles++;
                    chk("stall_ready", 32'(req_ready), 0);
                end
                if (m_valid && m_ready) begin
                    $display("tx byte 0x%02h (grant_id %0d)", m_data, grant_id);
                    if (exp_q.size() == 0)
                        fail_msg("byte", $sformatf("unexpected byte 0x%02h", m_data));
                    else
                        chk("byte", 32'(m_data), 32'(exp_q.pop_front()));
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_busy  = busy;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int s0;
        reset_n  = 1'b0;
        req_mask = '1;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_cycles = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
`ifdef UART_ARB_TIMEOUT_EN
        chk("rst_timeout_pulse", 32'(timeout_pulse), 0);
`endif
        reset_n = 1'b1;

        // 1: single 3-byte packet from requester 0, cycle-accurate.
        @(negedge clk);
        src(0, 8'h11, 0); src(0, 8'h22, 0); src(0, 8'h33, 1);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        exp_grant_q.push_back(0);
        @(negedge clk);
        chk("t1_busy_pre", 32'(busy), 0);
        chk("t1_idle_ready", 32'(req_ready), 0);
        @(negedge clk);
        chk("t1_grant", 32'(grant_id), 0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        chk("t1_mvalid0", 32'(m_valid), 1);
        @(negedge clk);
        chk("t1_mvalid1", 32'(m_valid), 1);
        chk("t1_busy_mid", 32'(busy), 1);
        @(negedge clk);
        chk("t1_mvalid2", 32'(m_valid), 1);
        chk("t1_busy_end", 32'(busy), 0);
        @(negedge clk);
        chk("t1_mvalid_off", 32'(m_valid), 0);
        drain("t1");

        // 2: req1 and req2 pending together from reset; then probe pointer==2.
        do_reset();
        src(1, 8'h1A, 0); src(1, 8'h1B, 1);
        src(2, 8'h2A, 0); src(2, 8'h2B, 1);
        exp_q.push_back(8'h1A); exp_q.push_back(8'h1B);
        exp_q.push_back(8'h2A); exp_q.push_back(8'h2B);
        exp_grant_q.push_back(1); exp_grant_q.push_back(2);
        drain("t2");
        src(0, 8'h40, 1); src(2, 8'h42, 1); src(3, 8'h43, 1);
        exp_q.push_back(8'h43); exp_q.push_back(8'h40); exp_q.push_back(8'h42);
        exp_grant_q.push_back(3); exp_grant_q.push_back(0); exp_grant_q.push_back(2);
        drain("t2b");

        // 3: all requesters continuously valid with single-byte packets.
        do_reset();
        for (int i = 0; i < N; i++) begin
            src(i, 8'(8'h30 + i), 1);
            src(i, 8'(8'h38 + i), 1);
        end
        for (int k = 0; k < 2 * N; k++) begin
            exp_grant_q.push_back(k % N);
            exp_q.push_back(8'((k < N) ? (8'h30 + k) : (8'h38 + k - N)));
        end
        drain("t3");

        // 4: m_ready pattern 1,0,0,1 in the middle of a 4-byte packet.
        @(negedge clk);
        s0 = stall_cycles;
        src(0, 8'h50, 0); src(0, 8'h51, 0); src(0, 8'h52, 0); src(0, 8'h53, 1);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h50 + k));
        exp_grant_q.push_back(0);
        rdy_q.push_back(1); rdy_q.push_back(1); rdy_q.push_back(1);
        rdy_q.push_back(0); rdy_q.push_back(0); rdy_q.push_back(1);
        drain("t4");
        chk("t4_stall_cycles", 32'(stall_cycles - s0), 2);

        // 5: mask req1 mid-packet while req3 waits.
        @(negedge clk);
        for (int k = 0; k < 4; k++) src(1, 8'(8'h70 + k), (k == 3));
        src(1, 8'h74, 1);
        src(3, 8'h7F, 1);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h70 + k));
        exp_q.push_back(8'h7F);
        exp_grant_q.push_back(1); exp_grant_q.push_back(3);
        repeat (3) @(negedge clk);
        req_mask[1] = 1'b0;
        drain("t5");
        repeat (10) @(negedge clk);
        chk("t5_req1_held_off", 32'(src_q[1].size()), 1);
        chk("t5_idle", 32'(busy), 0);
        exp_q.push_back(8'h74);
        exp_grant_q.push_back(1);
        req_mask[1] = 1'b1;
        drain("t5b");

`ifdef UART_ARB_TIMEOUT_EN
        // 6: req0 stops mid-packet; timeout after 5 stalled cycles, req2 next.
        timeout_cycles = 16'd5;
        do_reset();
        src(0, 8'h60, 0);
        src(2, 8'h62, 1);
        exp_q.push_back(8'h60); exp_q.push_back(8'h62);
        exp_grant_q.push_back(0); exp_grant_q.push_back(2);
        repeat (7) @(negedge clk);
        chk("t6_pulse_pre", 32'(timeout_pulse), 0);
        chk("t6_busy_pre", 32'(busy), 1);
        @(negedge clk);
        chk("t6_pulse", 32'(timeout_pulse), 1);
        chk("t6_busy_drop", 32'(busy), 0);
        @(negedge clk);
        chk("t6_pulse_off", 32'(timeout_pulse), 0);
        chk("t6_regrant", 32'(grant_id), 2);
        drain("t6");
        timeout_cycles = '0;
`endif

        // 7: reset mid-packet clears output immediately; priority restarts at 0.
        @(negedge clk);
        for (int k = 0; k < 4; k++) src(2, 8'(8'h80 + k), (k == 3));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h80 + k));
        exp_grant_q.push_back(2);
        repeat (4) @(negedge clk);
        chk("t7_busy_before", 32'(busy), 1);
        #2;
        reset_n = 1'b0;
        flush_all();
        #1;
        chk("t7_rst_m_valid", 32'(m_valid), 0);
        chk("t7_rst_m_data", 32'(m_data), 0);
        chk("t7_rst_busy", 32'(busy), 0);
        chk("t7_rst_ready", 32'(req_ready), 0);
        chk("t7_rst_grant", 32'(grant_id), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        src(3, 8'h93, 1);
        src(0, 8'h90, 1);
        exp_q.push_back(8'h90); exp_q.push_back(8'h93);
        exp_grant_q.push_back(0); exp_grant_q.push_back(3);
        drain("t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
